// File: rtl/phy2mac_os_gen.sv
// PHY-to-MAC ordered-set generator: streams SKP/TS1/TS2 ordered sets selected by the
// LTSSM state, BYTES_PER_CLK symbols per beat, with optional periodic SKP insertion.
package phy2mac_os_gen_pkg;
    typedef enum logic [3:0] {
        DETECT_QUIET, DETECT_ACTIVE, POLLING_ACTIVE, POLLING_ACTIVE_START_TS1,
        POLLING_CONFIG, POLLING_COMPLIANCE, CONFIG_LINKWIDTH_START, CONFIG_LINKWIDTH_ACCEPT,
        CONFIG_LANENUM_WAIT, CONFIG_COMPLETE, CONFIG_IDLE, L0,
        RECOVERY_RCVRLOCK, RECOVERY_IDLE, HOT_RESET, DISABLED
    } LTSSM_State;

    // Symbol codes matching the ozdefs.sv definitions.
    localparam logic [7:0] SYM_COM   = 8'hBC;
    localparam logic [7:0] SYM_SKP   = 8'h1C;
    localparam logic [7:0] SYM_TS1ID = 8'h4A;
    localparam logic [7:0] SYM_TS2ID = 8'h45;
endpackage

module phy2mac_os_gen
    import phy2mac_os_gen_pkg::*;
#(
    parameter int BYTES_PER_CLK = 1,
    parameter int SKP_LEN       = 4,
    parameter int SKP_INTERVAL  = 0,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       p2md_rstn,
    input  logic                       en_n,
    input  LTSSM_State                 currLtssmState,
    input  logic [39:0]                ts1Bytes1Thru5,
    input  logic [39:0]                ts2Bytes1Thru5,
    output logic [8*BYTES_PER_CLK-1:0] rxdata,
    output logic [BYTES_PER_CLK-1:0]   rxdatak,
    output logic                       rxvalid,
    output logic                       os_done,
    output logic [1:0]                 os_type,
    output logic [CNT_W-1:0]           os_count
);

    generate
        if (BYTES_PER_CLK != 1 && BYTES_PER_CLK != 2 && BYTES_PER_CLK != 4) begin : g_bad_bpc
            $fatal(1, "BYTES_PER_CLK must be 1, 2 or 4");
        end
        if (SKP_LEN < 2 || SKP_LEN > 8 || (SKP_LEN % BYTES_PER_CLK) != 0) begin : g_bad_skp
            $fatal(1, "SKP_LEN must be 2..8 and a multiple of BYTES_PER_CLK");
        end
        if (SKP_INTERVAL < 0 || SKP_INTERVAL > 255) begin : g_bad_int
            $fatal(1, "SKP_INTERVAL must be 0..255");
        end
    endgenerate

    localparam logic [3:0] TS_LAST  = 4'(16 / BYTES_PER_CLK - 1);
    localparam logic [3:0] SKP_LAST = 4'(SKP_LEN / BYTES_PER_CLK - 1);
    localparam logic [7:0] GAP_MAX  = 8'(SKP_INTERVAL);

    // Mode codes double as os_type encodings.
    localparam logic [1:0] M_NONE = 2'd0;
    localparam logic [1:0] M_SKP  = 2'd1;
    localparam logic [1:0] M_TS1  = 2'd2;
    localparam logic [1:0] M_TS2  = 2'd3;

    typedef enum logic [1:0] {IDLE, SEND_SKP, SEND_TS, INS_SKP} state_t;

    state_t                     state_reg, state_next;
    logic [3:0]                 beat_reg, beat_next;
    logic [1:0]                 mode_reg, mode_next;
    logic                       chg_reg, chg_next;
    logic [7:0]                 gap_reg, gap_next;
    logic [39:0]                field_reg;
    logic [CNT_W-1:0]           count_next;
    logic [8*BYTES_PER_CLK-1:0] rxdata_next;
    logic [BYTES_PER_CLK-1:0]   rxdatak_next;
    logic [1:0]                 os_type_next;

    logic [1:0]                 mode_in;
    logic                       busy, last_beat, first_beat, ts_done, boundary, mode_chg;
    logic [7:0]                 gap_inc;
    logic [39:0]                field_live, field_use;
    logic [7:0]                 ts_id;
    logic [8*BYTES_PER_CLK-1:0] beat_data;
    logic [BYTES_PER_CLK-1:0]   beat_k;

    always_comb begin
        case (currLtssmState)
            POLLING_ACTIVE:           mode_in = M_SKP;
            POLLING_ACTIVE_START_TS1: mode_in = M_TS1;
            POLLING_CONFIG:           mode_in = M_TS2;
            default:                  mode_in = M_NONE;
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign last_beat  = busy && (beat_reg == ((state_reg == SEND_TS) ? TS_LAST : SKP_LAST));
    assign first_beat = busy && (beat_reg == 4'd0);
    assign ts_done    = last_beat && (state_reg == SEND_TS);
    assign boundary   = !busy || last_beat;
    assign mode_chg   = (mode_in != mode_reg);
    assign gap_inc    = (ts_done && gap_reg != GAP_MAX) ? gap_reg + 8'd1 : gap_reg;
    assign field_live = (mode_reg == M_TS2) ? ts2Bytes1Thru5 : ts1Bytes1Thru5;
    // Beat 0 reads the live field directly; later beats use the copy taken at beat 0.
    assign field_use  = first_beat ? field_live : field_reg;
    assign ts_id      = (mode_reg == M_TS2) ? SYM_TS2ID : SYM_TS1ID;

    generate
        for (genvar gi = 0; gi < BYTES_PER_CLK; gi++) begin : g_lane
            logic [4:0] idx;
            logic [8:0] sym;

            assign idx = 5'(beat_reg) * 5'(BYTES_PER_CLK) + 5'(gi);

            always_comb begin
                sym = {1'b1, SYM_SKP};
                if (state_reg == SEND_TS) begin
                    case (idx)
                        5'd0:    sym = {1'b1, SYM_COM};
                        5'd1:    sym = {1'b0, field_use[7:0]};
                        5'd2:    sym = {1'b0, field_use[15:8]};
                        5'd3:    sym = {1'b0, field_use[23:16]};
                        5'd4:    sym = {1'b0, field_use[31:24]};
                        5'd5:    sym = {1'b0, field_use[39:32]};
                        default: sym = {1'b0, ts_id};
                    endcase
                end else if (idx == 5'd0) begin
                    sym = {1'b1, SYM_COM};
                end
            end

            assign beat_data[8*gi +: 8] = sym[7:0];
            assign beat_k[gi]           = sym[8];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        beat_next    = busy ? (last_beat ? 4'd0 : beat_reg + 4'd1) : 4'd0;
        mode_next    = mode_reg;
        chg_next     = chg_reg;
        gap_next     = gap_inc;
        count_next   = os_count;
        rxdata_next  = '0;
        rxdatak_next = '0;
        os_type_next = M_NONE;

        if (boundary) begin
            beat_next = 4'd0;
            if (en_n || mode_in == M_NONE) begin
                state_next = IDLE;
            end else begin
                chg_next  = mode_chg;
                mode_next = mode_in;
                if (mode_chg) gap_next = 8'd0;
                if (mode_in == M_SKP) begin
                    state_next = SEND_SKP;
                end else if (SKP_INTERVAL != 0 && !mode_chg && gap_inc == GAP_MAX) begin
                    state_next = INS_SKP;
                    gap_next   = 8'd0;
                end else begin
                    state_next = SEND_TS;
                end
            end
        end

        // The count clears on the first beat after a mode change so the final beat
        // of the old OS still shows its completed total.
        if (first_beat && chg_reg) count_next = '0;
        if (ts_done && !(&count_next)) count_next = count_next + CNT_W'(1);

        if (busy) begin
            rxdata_next  = beat_data;
            rxdatak_next = beat_k;
            os_type_next = (state_reg == SEND_TS) ? mode_reg : M_SKP;
        end
    end

    always_ff @(posedge clk) begin
        if (!p2md_rstn) begin
            state_reg <= IDLE;
            beat_reg  <= 4'd0;
            mode_reg  <= M_NONE;
            chg_reg   <= 1'b0;
            gap_reg   <= 8'd0;
            field_reg <= '0;
            rxdata    <= '0;
            rxdatak   <= '0;
            rxvalid   <= 1'b0;
            os_done   <= 1'b0;
            os_type   <= 2'd0;
            os_count  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            mode_reg  <= mode_next;
            chg_reg   <= chg_next;
            gap_reg   <= gap_next;
            if (state_reg == SEND_TS && first_beat) field_reg <= field_live;
            rxdata    <= rxdata_next;
            rxdatak   <= rxdatak_next;
            rxvalid   <= busy;
            os_done   <= last_beat;
            os_type   <= os_type_next;
            os_count  <= count_next;
        end
    end

endmodule

// File: tb/tb_phy2mac_os_gen.sv
// Scoreboard bench for phy2mac_os_gen: three instances (1, 4 and 2 bytes per clock),
// expected beats queued with their arrival cycle and checked by a negedge monitor.
module tb_phy2mac_os_gen;
    import phy2mac_os_gen_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [3:0]  k;
        logic        done;
        logic [1:0]  typ;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        en_a, en_b, en_c;
    LTSSM_State  ltssm;
    logic [39:0] ts1, ts2;

    logic [7:0]  rxdata_a;
    logic [31:0] rxdata_b;
    logic [15:0] rxdata_c;
    logic [0:0]  rxdatak_a;
    logic [3:0]  rxdatak_b;
    logic [1:0]  rxdatak_c;
    logic        rxvalid_a, rxvalid_b, rxvalid_c;
    logic        os_done_a, os_done_b, os_done_c;
    logic [1:0]  os_type_a, os_type_b, os_type_c;
    logic [15:0] os_count_a, os_count_b, os_count_c;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[3][$];

    phy2mac_os_gen #(.BYTES_PER_CLK(1), .SKP_LEN(4), .SKP_INTERVAL(2), .CNT_W(16)) dut_a (
        .clk(clk), .p2md_rstn(rstn), .en_n(en_a), .currLtssmState(ltssm),
        .ts1Bytes1Thru5(ts1), .ts2Bytes1Thru5(ts2),
        .rxdata(rxdata_a), .rxdatak(rxdatak_a), .rxvalid(rxvalid_a),
        .os_done(os_done_a), .os_type(os_type_a), .os_count(os_count_a));

    phy2mac_os_gen #(.BYTES_PER_CLK(4), .SKP_LEN(4), .SKP_INTERVAL(0), .CNT_W(16)) dut_b (
        .clk(clk), .p2md_rstn(rstn), .en_n(en_b), .currLtssmState(ltssm),
        .ts1Bytes1Thru5(ts1), .ts2Bytes1Thru5(ts2),
        .rxdata(rxdata_b), .rxdatak(rxdatak_b), .rxvalid(rxvalid_b),
        .os_done(os_done_b), .os_type(os_type_b), .os_count(os_count_b));

    phy2mac_os_gen #(.BYTES_PER_CLK(2), .SKP_LEN(4), .SKP_INTERVAL(0), .CNT_W(16)) dut_c (
        .clk(clk), .p2md_rstn(rstn), .en_n(en_c), .currLtssmState(ltssm),
        .ts1Bytes1Thru5(ts1), .ts2Bytes1Thru5(ts2),
        .rxdata(rxdata_c), .rxdatak(rxdatak_c), .rxvalid(rxvalid_c),
        .os_done(os_done_c), .os_type(os_type_c), .os_count(os_count_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bpc_of(input int inst);
        return (inst == 0) ? 1 : (inst == 1) ? 4 : 2;
    endfunction

    // Queue every beat of one OS: typ 1 = SKP (length 4), 2 = TS1, 3 = TS2.
    task automatic push_os(input int inst, input int start, input int typ, input logic [39:0] f,
                           input int cnt_during, input int cnt_last);
        logic [7:0] s [16];
        logic       kk [16];
        int         bpc, len, nb;
        exp_t       e;
        bpc = bpc_of(inst);
        len = (typ == 1) ? 4 : 16;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                s[i] = 8'hBC; kk[i] = 1'b1;
            end else if (typ == 1) begin
                s[i] = 8'h1C; kk[i] = 1'b1;
            end else if (i <= 5) begin
                s[i] = f[8*(i-1) +: 8]; kk[i] = 1'b0;
            end else begin
                s[i] = (typ == 2) ? 8'h4A : 8'h45; kk[i] = 1'b0;
            end
        end
        nb = len / bpc;
        for (int b = 0; b < nb; b++) begin
            e.cyc  = start + b;
            e.data = '0;
            e.k    = '0;
            for (int j = 0; j < bpc; j++) begin
                e.data[8*j +: 8] = s[b*bpc + j];
                e.k[j]           = kk[b*bpc + j];
            end
            e.done = (b == nb - 1);
            e.typ  = 2'(typ);
            e.cnt  = 16'((b == nb - 1) ? cnt_last : cnt_during);
            q[inst].push_back(e);
        end
    endtask

    task automatic check_port(input int inst, input logic v, input logic [31:0] d, input logic [3:0] k,
                              input logic dn, input logic [1:0] t, input logic [15:0] c);
        exp_t e;
        checks++;
        if (v === 1'b1) begin
            if (q[inst].size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat inst%0d cyc=%0d got data=%h k=%h", inst, cyc, d, k);
            end else begin
                e = q[inst].pop_front();
                if (e.cyc != cyc || e.data !== d || e.k !== k || e.done !== dn || e.typ !== t || e.cnt !== c) begin
                    errors++;
                    $display("FAIL beat inst%0d got cyc=%0d data=%h k=%h done=%b type=%0d cnt=%0d, want cyc=%0d data=%h k=%h done=%b type=%0d cnt=%0d",
                             inst, cyc, d, k, dn, t, c, e.cyc, e.data, e.k, e.done, e.typ, e.cnt);
                end else if (dn) begin
                    $display("inst%0d cyc=%0d os complete type=%0d os_count=%0d", inst, cyc, t, c);
                end
            end
        end else begin
            if (v !== 1'b0 || d !== 32'd0 || k !== 4'd0 || dn !== 1'b0 || t !== 2'd0) begin
                errors++;
                $display("FAIL idle_outputs inst%0d cyc=%0d got valid=%b data=%h k=%h done=%b type=%0d, want all zero",
                         inst, cyc, v, d, k, dn, t);
            end
            if (q[inst].size() > 0 && q[inst][0].cyc < cyc) begin
                checks++;
                errors++;
                e = q[inst].pop_front();
                $display("FAIL missing_beat inst%0d got no beat by cyc=%0d, want data=%h at cyc=%0d",
                         inst, cyc, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        check_port(0, rxvalid_a, 32'(rxdata_a), 4'(rxdatak_a), os_done_a, os_type_a, os_count_a);
        check_port(1, rxvalid_b, rxdata_b, rxdatak_b, os_done_b, os_type_b, os_count_b);
        check_port(2, rxvalid_c, 32'(rxdata_c), 4'(rxdatak_c), os_done_c, os_type_c, os_count_c);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int   c;
        exp_t e_tmp;
        rstn  = 1'b0;
        en_a  = 1'b1;
        en_b  = 1'b1;
        en_c  = 1'b1;
        ltssm = DETECT_QUIET;
        ts1   = 40'h0504030201;
        ts2   = 40'hF5F4F3F2F1;
        tick(3);
        chk("reset_count_a", 32'(os_count_a), 0);
        chk("reset_count_b", 32'(os_count_b), 0);
        chk("reset_count_c", 32'(os_count_c), 0);
        rstn = 1'b1;
        tick(2);

        // One TS2 at 1 byte/clk; en_n raised mid-OS ends the stream after it.
        c = cyc;
        ltssm = POLLING_CONFIG;
        en_a  = 1'b0;
        push_os(0, c + 2, 3, 40'hF5F4F3F2F1, 0, 1);
        tick(5);
        en_a = 1'b1;
        tick(16);

        // Five single-beat SKPs at 4 bytes/clk.
        c = cyc;
        ltssm = POLLING_ACTIVE;
        en_b  = 1'b0;
        for (int i = 0; i < 5; i++) push_os(1, c + 2 + i, 1, 40'd0, 0, 0);
        tick(5);
        en_b = 1'b1;
        tick(4);

        // TS1 at 2 bytes/clk; field changes after beat 0 only reach the next OS.
        c = cyc;
        ltssm = POLLING_ACTIVE_START_TS1;
        en_c  = 1'b0;
        push_os(2, c + 2, 2, 40'h0504030201, 0, 1);
        tick(2);
        ts1 = 40'h0A09080706;
        push_os(2, c + 10, 2, 40'h0A09080706, 1, 2);
        tick(10);
        en_c = 1'b1;
        tick(10);

        // TS1 streaming with a SKP every two TS1s, then a switch to TS2 during beat 7.
        ts1 = 40'h1514131211;
        c = cyc;
        en_a = 1'b0;
        push_os(0, c + 2,  2, ts1, 0, 1);
        push_os(0, c + 18, 2, ts1, 1, 2);
        push_os(0, c + 34, 1, ts1, 2, 2);
        push_os(0, c + 38, 2, ts1, 2, 3);
        push_os(0, c + 54, 2, ts1, 3, 4);
        push_os(0, c + 70, 1, ts1, 4, 4);
        push_os(0, c + 74, 2, ts1, 4, 5);
        push_os(0, c + 90, 3, ts2, 0, 1);
        tick(81);
        ltssm = POLLING_CONFIG;
        tick(14);
        en_a = 1'b1;
        tick(15);

        // Reset lands where beat 5 would be: beats 0..4 only, then a clean restart.
        c = cyc;
        en_a = 1'b0;
        push_os(0, c + 2, 3, ts2, 1, 1);
        for (int i = 0; i < 11; i++) e_tmp = q[0].pop_back();
        tick(6);
        rstn = 1'b0;
        tick(1);
        chk("midos_reset_count_a", 32'(os_count_a), 0);
        chk("midos_reset_valid_a", 32'(rxvalid_a), 0);
        tick(1);
        rstn = 1'b1;
        push_os(0, c + 10, 3, ts2, 0, 1);
        tick(4);
        en_a = 1'b1;
        tick(20);

        chk("queue_empty_a", 32'(q[0].size()), 0);
        chk("queue_empty_b", 32'(q[1].size()), 0);
        chk("queue_empty_c", 32'(q[2].size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
